addsub_sched: RTL and testbench
===============================

# addsub_sched

Round-robin scheduler that shares one 4-bit ripple add/subtract unit between two requesters. Each request carries a mode bit and two 4-bit operands. The block latches the winning request and drives the shared unit's mode and operand inputs for a programmable number of settle cycles. It then captures sum, carry and signed overflow and returns them to the owning requester over a valid/ready response channel. It sits between client logic and the combinational add/sub datapath, which it instantiates nowhere; the unit is connected externally through the `au_*` ports.

## Interface
- `EXEC_CYCLES`, default 1: settle cycles allowed for the ripple path. Legal range 1..15; held in a 4-bit counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 2: per-requester request valid; bit i belongs to requester i.
- `req_ready` out 2: per-requester accept; at most one bit high in any cycle.
- `req_m0`, `req_m1` in 1: mode for requester 0/1; 0 = add (a+b), 1 = subtract (a−b).
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 4: operands.
- `rsp_valid` out 2: response valid; at most one bit high in any cycle.
- `rsp_ready` in 2: response accept from requester i.
- `rsp_s` out 4: result sum.
- `rsp_cout` out 1: carry out; for subtract, 1 = no borrow (a ≥ b unsigned).
- `rsp_ovf` out 1: two's-complement overflow.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `au_m` out 1: mode to the shared unit.
- `au_a`, `au_b` out 4: operands to the shared unit; b is raw and the unit applies the XOR with m.
- `au_s` in 4, `au_cout` in 1: results from the shared unit.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid` bit is set, grant the winner, latch mode/operands/owner, go to EXEC.
  - EXEC: count EXEC_CYCLES cycles; on the last one capture the result, go to RESP.
  - RESP: hold the response until `rsp_ready[owner]`, then go to IDLE.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the winner is the requester not granted last time.
  - Priority pointer resets to favour requester 0 and updates at each grant.
- `req_ready[w]` is combinational, high only in IDLE for the winner `w`. The request transfers on `req_valid[w] & req_ready[w]`.
- Requesters must hold valid and payload stable until accepted.
- `au_m`/`au_a`/`au_b` are driven from latched registers. They are stable through all of EXEC and hold their last value otherwise.
- Capture rules:
  - `rsp_s` = `au_s`; `rsp_cout` = `au_cout`.
  - `rsp_ovf` = (a[3] == bx[3]) & (au_s[3] != a[3]), where bx = b XOR {4{m}}.
- In RESP, `rsp_valid[owner]` = 1 and `rsp_s`/`rsp_cout`/`rsp_ovf` are held constant until the handshake.
- `rsp_ready` of the non-owner is ignored.
- No new grant is made in RESP; `req_ready` = 0 in EXEC and RESP.
- Reset values:
  - Outputs: `req_ready` 0, `rsp_valid` 0, `rsp_s`/`rsp_cout`/`rsp_ovf` 0, `au_m`/`au_a`/`au_b` 0, `busy` 0.
  - Internal: state IDLE, pointer to requester 0, counter 0.
- Reset asserted in any state takes effect at the next edge. Any in-flight operation is discarded with no response, and the pointer reverts to requester 0.

## Timing
- With grant at cycle T (IDLE, handshake):
  - EXEC occupies T+1 .. T+EXEC_CYCLES.
  - The result is captured at the end of T+EXEC_CYCLES.
  - `rsp_valid` is high from T+EXEC_CYCLES+1.
- The response handshake at cycle R returns the FSM to IDLE at R+1. The earliest next grant is R+1.
- Minimum issue interval is EXEC_CYCLES+2 cycles. With EXEC_CYCLES=1, back-to-back requests complete every 3 cycles.
- `busy` rises at T+1 and falls at R+1.
- Simultaneous `req_valid` from both requesters while in RESP: both wait. Arbitration happens only in IDLE, using the pointer value at that cycle.

## Test plan
- Add with overflow: requester 0, m=0, a=5, b=3, EXEC_CYCLES=1.
  - Expect `req_ready[0]` at T, `rsp_valid[0]` at T+2, s=8, cout=0, ovf=1.
- Subtract with borrow: requester 1, m=1, a=3, b=5.
  - Expect `au_m`=1 during EXEC, s=14, cout=0, ovf=0.
  - Second case a=7, b=8: s=15, cout=0, ovf=1.
- Contention: both requesters valid continuously from reset, `rsp_ready`=2'b11.
  - Grants alternate 0,1,0,1; never two `req_ready` bits high together.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid` and the data stay constant, `req_ready`=0, `busy`=1.
  - Completion follows one cycle after `rsp_ready` rises.
- EXEC_CYCLES=3, requester 0, a=9, b=6, m=0:
  - `au_a`/`au_b`/`au_m` stable for 3 cycles.
  - `rsp_valid` at T+4, s=15, cout=0, ovf=0.
- Reset mid-EXEC: drop `rst_n` one cycle into EXEC.
  - Next cycle `busy`=0 and `rsp_valid`=0; no response ever appears.
  - A subsequent dual request grants requester 0 first.

Source files
------------

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one external 4-bit add/subtract unit between two requesters.
// Latches the winning request, drives the unit for EXEC_CYCLES cycles, then returns the result.
module addsub_sched #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic       req_m0,
  input  logic       req_m1,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_b0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_s,
  output logic       rsp_cout,
  output logic       rsp_ovf,
  output logic       busy,
  output logic       au_m,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  input  logic [3:0] au_s,
  input  logic       au_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

  state_t     state, state_nxt;
  logic       ptr;
  logic       owner;
  logic [3:0] cnt;
  logic       win;
  logic       grant;
  logic       exec_done;
  logic       rsp_hs;

  // Sign-bit overflow rule; b is inverted for subtract exactly as the unit does internally.
  function automatic logic ovf_of(input logic m, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] s);
    logic [3:0] bx;
    bx = b ^ {4{m}};
    return (a[3] == bx[3]) && (s[3] != a[3]);
  endfunction

  // ptr names the requester favoured when both are valid.
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = ptr;
      default: win = 1'b0;
    endcase
  end

  assign grant     = (state == IDLE) && (req_valid != 2'b00);
  assign exec_done = (state == EXEC) && (cnt == LAST);
  assign rsp_hs    = (state == RESP) && rsp_ready[owner];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)     state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_hs)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = (state != IDLE);
    if (grant) req_ready[win] = 1'b1;
    if (state == RESP) rsp_valid[owner] = 1'b1;
  end

  // Control: arbitration pointer, owner and settle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
      cnt   <= 4'd0;
    end else if (grant) begin
      ptr   <= ~win;
      owner <= win;
      cnt   <= 4'd0;
    end else if ((state == EXEC) && !exec_done) begin
      cnt   <= cnt + 4'd1;
    end
  end

  // Operand latch feeding the unit, and result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      au_m     <= 1'b0;
      au_a     <= 4'd0;
      au_b     <= 4'd0;
      rsp_s    <= 4'd0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (grant) begin
      au_m <= win ? req_m1 : req_m0;
      au_a <= win ? req_a1 : req_a0;
      au_b <= win ? req_b1 : req_b0;
    end else if (exec_done) begin
      rsp_s    <= au_s;
      rsp_cout <= au_cout;
      rsp_ovf  <= ovf_of(au_m, au_a, au_b, au_s);
    end
  end

endmodule

// File: tb/tb_addsub_sched.sv
// Bench for addsub_sched: arithmetic reference model checked every cycle plus literal directed cases.
module tb_addsub_sched;

  localparam int EC = 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic       req_m0, req_m1;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0] rsp_s, au_a, au_b, au_s;
  logic       rsp_cout, rsp_ovf, busy, au_m, au_cout;

  logic [1:0] r3_valid, r3_ready, v3_valid, v3_ready;
  logic       r3_m;
  logic [3:0] r3_a, r3_b, s3, a3, b3, au_s3;
  logic       c3, o3, busy3, m3, au_c3;

  int vectors = 0;
  int miscompares = 0;

  addsub_sched #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_m0(req_m0), .req_m1(req_m1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy),
    .au_m(au_m), .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_cout(au_cout));

  addsub_sched #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_m0(r3_m), .req_m1(1'b0), .req_a0(r3_a), .req_b0(r3_b),
    .req_a1(4'd0), .req_b1(4'd0), .rsp_valid(v3_valid), .rsp_ready(v3_ready),
    .rsp_s(s3), .rsp_cout(c3), .rsp_ovf(o3), .busy(busy3),
    .au_m(m3), .au_a(a3), .au_b(b3), .au_s(au_s3), .au_cout(au_c3));

  // External ripple add/subtract units.
  logic [4:0] sum5, sum5_3;
  assign sum5    = {1'b0, au_a} + {1'b0, au_b ^ {4{au_m}}} + {4'd0, au_m};
  assign au_s    = sum5[3:0];
  assign au_cout = sum5[4];
  assign sum5_3  = {1'b0, a3} + {1'b0, b3 ^ {4{m3}}} + {4'd0, m3};
  assign au_s3   = sum5_3[3:0];
  assign au_c3   = sum5_3[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Expected result from plain integer arithmetic: {ovf, cout, s}.
  function automatic int expect_res(input int m, input int a, input int b);
    int raw, sr, s, c, o;
    raw = m ? a - b : a + b;
    s   = raw & 15;
    c   = m ? int'(a >= b) : int'(raw > 15);
    sr  = m ? sgn4(a) - sgn4(b) : sgn4(a) + sgn4(b);
    o   = int'((sr > 7) || (sr < -8));
    return (o << 5) | (c << 4) | s;
  endfunction

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  // Transaction-level model: outstanding flag, cycles since grant, owner, last grant.
  bit armed = 0;
  bit m_out = 0;
  int m_age = 0, m_own = 0, m_last = 1;
  int m_m = 0, m_a = 0, m_b = 0, m_res = 0;

  always @(negedge clk) begin
    int exp_rv, exp_rr, w;
    if (armed) begin
      chk("busy", busy, m_out);
      exp_rv = (m_out && m_age > EC) ? (1 << m_own) : 0;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 0) begin
        chk("rsp_s", rsp_s, m_res & 15);
        chk("rsp_cout", rsp_cout, (m_res >> 4) & 1);
        chk("rsp_ovf", rsp_ovf, (m_res >> 5) & 1);
      end
      chk("au_m", au_m, m_m);
      chk("au_a", au_a, m_a);
      chk("au_b", au_b, m_b);
      exp_rr = (!m_out && req_valid != 2'b00) ? (1 << pick(req_valid, m_last)) : 0;
      chk("req_ready", req_ready, exp_rr);
    end
    if (!rst_n) begin
      m_out = 0; m_last = 1; m_m = 0; m_a = 0; m_b = 0; armed = 1;
    end else if (!m_out) begin
      if (req_valid != 2'b00) begin
        w = pick(req_valid, m_last);
        m_last = w; m_own = w; m_out = 1; m_age = 1;
        m_m = w ? req_m1 : req_m0;
        m_a = w ? req_a1 : req_a0;
        m_b = w ? req_b1 : req_b0;
      end
    end else begin
      if (m_age == EC) m_res = expect_res(m_m, m_a, m_b);
      if (m_age > EC && rsp_ready[m_own]) m_out = 0;
      m_age++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input bit m, input int a, input int b);
    if (r == 0) begin req_m0 = m; req_a0 = 4'(a); req_b0 = 4'(b); end
    else        begin req_m1 = m; req_a1 = 4'(a); req_b1 = 4'(b); end
    req_valid[r] = 1'b1;
  endtask

  task automatic one_req(input int r, input bit m, input int a, input int b,
                         input int es, input int ec, input int eo);
    int n;
    step();
    set_req(r, m, a, b);
    #2 chk("grant_ready", req_ready, 1 << r);
    step();
    req_valid = 2'b00;
    chk("exec_au_m", au_m, m);
    chk("exec_au_a", au_a, a);
    chk("exec_au_b", au_b, b);
    n = 1;
    while (!rsp_valid[r] && n < 20) begin step(); n++; end
    chk("rsp_latency", n, EC + 1);
    chk("lit_s", rsp_s, es);
    chk("lit_cout", rsp_cout, ec);
    chk("lit_ovf", rsp_ovf, eo);
    step();
  endtask

  initial begin
    int q[$];
    logic [1:0] acc;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    req_m0 = 0; req_m1 = 0; req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    r3_valid = 2'b00; v3_ready = 2'b11; r3_m = 0; r3_a = 0; r3_b = 0;
    do_reset();

    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_s", rsp_s, 0);
    chk("reset_au_a", au_a, 0);

    one_req(0, 1'b0, 5, 3, 8, 0, 1);
    one_req(1, 1'b1, 3, 5, 14, 0, 0);
    one_req(1, 1'b1, 7, 8, 15, 0, 1);

    // Contention from reset: grants must alternate starting with requester 0.
    do_reset();
    set_req(0, 1'b0, 1, 2);
    set_req(1, 1'b1, 9, 4);
    for (int i = 0; i < 14; i++) begin
      #2 if (req_ready != 2'b00) q.push_back(req_ready);
      step();
    end
    req_valid = 2'b00;
    chk("contention_grants", q.size() >= 4, 1);
    if (q.size() >= 4) begin
      chk("grant0", q[0], 1);
      chk("grant1", q[1], 2);
      chk("grant2", q[2], 1);
      chk("grant3", q[3], 2);
    end
    repeat (4) step();

    // Response backpressure with a competing request waiting.
    rsp_ready = 2'b00;
    set_req(0, 1'b0, 2, 2);
    step();
    req_valid = 2'b00;
    set_req(1, 1'b0, 1, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_s", rsp_s, 4);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    rsp_ready = 2'b01;
    #1 chk("bp_hold_last", rsp_valid, 1);
    step();
    chk("bp_done_busy", busy, 0);
    chk("bp_next_grant", req_ready, 2);
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) step();

    // Reset one cycle into EXEC discards the operation and restores the pointer.
    set_req(0, 1'b0, 6, 1);
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_rsp", rsp_valid, 0);
      step();
    end
    set_req(0, 1'b0, 3, 3);
    set_req(1, 1'b0, 4, 4);
    #2 chk("rst_ptr_grant", req_ready, 1);
    step();
    req_valid[0] = 1'b0;
    repeat (6) step();
    req_valid = 2'b00;
    repeat (4) step();

    // EXEC_CYCLES = 3 instance.
    r3_m = 1'b0; r3_a = 4'd9; r3_b = 4'd6; r3_valid = 2'b01;
    #2 chk("ec3_grant", r3_ready, 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      r3_valid = 2'b00;
      chk("ec3_au_a", a3, 9);
      chk("ec3_au_b", b3, 6);
      chk("ec3_au_m", m3, 0);
      chk("ec3_no_rsp", v3_valid, 0);
    end
    step();
    chk("ec3_rsp_valid", v3_valid, 1);
    chk("ec3_s", s3, 15);
    chk("ec3_cout", c3, 0);
    chk("ec3_ovf", o3, 0);
    step();

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 1500; i++) begin
      #1 acc = req_valid & req_ready;
      step();
      for (int r = 0; r < 2; r++) begin
        if (acc[r] || !req_valid[r]) begin
          req_valid[r] = 1'b0;
          if ($urandom_range(2) == 0)
            set_req(r, 1'($urandom), int'($urandom_range(15)), int'($urandom_range(15)));
        end
      end
      rsp_ready = 2'($urandom);
      rst_n = ($urandom_range(199) != 0);
    end
    rst_n = 1'b1;
    req_valid = 2'b00;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
